// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter
//
// Round-robin arbiter and transaction sequencer that shares one byte-level
// spi_master among NUM_REQ requesters. One requester owns the bus at a time.
// The owner keeps a transaction-level chip select low for its whole burst.
// Each byte is launched with a one-cycle start pulse, and every received byte
// is returned to the owner. An idle gap is enforced between transactions.
//
// Optional feature: define SPI_ARB_TIMEOUT_EN to build a per-byte watchdog.
// If TIMEOUT_CYCLES pass in WAIT without spi_done, the burst is aborted with
// txn_err. Without the macro txn_err is always 0 and WAIT waits forever.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   req_valid     per-requester request, held until its txn_done
//   req_len       per-requester byte count minus one (LEN_W bits per slice)
//   req_wdata     per-requester current byte to send (8 bits per slice)
//   grant         one-hot current owner, zero when idle
//   wdata_ack     pulse: owner's byte captured, present the next one
//   rdata         last received byte
//   rdata_valid   pulse to owner: rdata is valid
//   txn_done      pulse to owner at end of burst
//   txn_err       pulse to owner on watchdog abort
//   cs_n          transaction chip select, active low
//   spi_start     one-cycle start to spi_master
//   spi_wdata     byte to spi_master
//   spi_rdata     byte from spi_master
//   spi_done      byte complete from spi_master
module spi_txn_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned LEN_W          = 4,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    input  logic [NUM_REQ*8-1:0]     req_wdata,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       wdata_ack,
    output logic [7:0]               rdata,
    output logic [NUM_REQ-1:0]       rdata_valid,
    output logic [NUM_REQ-1:0]       txn_done,
    output logic [NUM_REQ-1:0]       txn_err,
    output logic                     cs_n,
    output logic                     spi_start,
    output logic [7:0]               spi_wdata,
    input  logic [7:0]               spi_rdata,
    input  logic                     spi_done
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // The gap counter holds GAP_CYCLES-1 down to 0.
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    // Encoding values outside the four states fall back to StIdle.
    typedef enum logic [2:0] {
        StIdle = 3'b000,
        StLoad = 3'b001,
        StWait = 3'b010,
        StGap  = 3'b100
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   wdata_ack_q, wdata_ack_d;
    logic [7:0]           rdata_q, rdata_d;
    logic [NUM_REQ-1:0]   rdata_valid_q, rdata_valid_d;
    logic [NUM_REQ-1:0]   txn_done_q, txn_done_d;
    logic [NUM_REQ-1:0]   txn_err_q, txn_err_d;
    logic                 cs_n_q, cs_n_d;
    logic                 spi_start_q, spi_start_d;
    logic [7:0]           spi_wdata_q, spi_wdata_d;

    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     scan_idx;
    logic [LEN_W-1:0]     pick_len;
    logic [7:0]           own_wdata;
    logic                 byte_done;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
`else
    logic                 unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Round-robin scan starting one past the last winner, with wrap.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            scan_idx = IDX_W'((int'(ptr_q) + k) % int'(NUM_REQ));
            if (!pick_found && req_valid[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    // Slice muxes: length of the candidate, write byte of the current owner.
    always_comb begin
        pick_len  = '0;
        own_wdata = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_len = req_len[i*LEN_W +: LEN_W];
            end
            if (grant_q[i]) begin
                own_wdata = req_wdata[i*8 +: 8];
            end
        end
    end

    // A done seen while our own start pulse is still high belongs to an
    // earlier byte and is dropped.
    assign byte_done = spi_done && !spi_start_q;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        gap_d         = gap_q;
        grant_d       = grant_q;
        wdata_ack_d   = '0;
        rdata_d       = rdata_q;
        rdata_valid_d = '0;
        txn_done_d    = '0;
        txn_err_d     = '0;
        cs_n_d        = cs_n_q;
        spi_start_d   = 1'b0;
        spi_wdata_d   = spi_wdata_q;
`ifdef SPI_ARB_TIMEOUT_EN
        tmo_d         = tmo_q;
`endif
        case (state_q)
            StIdle: begin
                if (pick_found) begin
                    for (int i = 0; i < int'(NUM_REQ); i++) begin
                        grant_d[i] = (pick_idx == IDX_W'(i));
                    end
                    cs_n_d  = 1'b0;
                    cnt_d   = pick_len;
                    ptr_d   = pick_idx;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                spi_start_d = 1'b1;
                spi_wdata_d = own_wdata;
                wdata_ack_d = grant_q;
`ifdef SPI_ARB_TIMEOUT_EN
                tmo_d       = '0;
`endif
                state_d     = StWait;
            end
            StWait: begin
                if (byte_done) begin
                    rdata_d       = spi_rdata;
                    rdata_valid_d = grant_q;
                    if (cnt_q == '0) begin
                        txn_done_d = grant_q;
                        grant_d    = '0;
                        cs_n_d     = 1'b1;
                        gap_d      = GAP_W'(GAP_CYCLES - 1);
                        state_d    = StGap;
                    end else begin
                        cnt_d   = cnt_q - LEN_W'(1);
                        state_d = StLoad;
                    end
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    txn_err_d = grant_q;
                    grant_d   = '0;
                    cs_n_d    = 1'b1;
                    gap_d     = GAP_W'(GAP_CYCLES - 1);
                    state_d   = StGap;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            StGap: begin
                if (gap_q == '0) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                grant_d = '0;
                cs_n_d  = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            ptr_q         <= IDX_W'(NUM_REQ - 1);
            cnt_q         <= '0;
            gap_q         <= '0;
            grant_q       <= '0;
            wdata_ack_q   <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= '0;
            txn_done_q    <= '0;
            txn_err_q     <= '0;
            cs_n_q        <= 1'b1;
            spi_start_q   <= 1'b0;
            spi_wdata_q   <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            tmo_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            gap_q         <= gap_d;
            grant_q       <= grant_d;
            wdata_ack_q   <= wdata_ack_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            txn_done_q    <= txn_done_d;
            txn_err_q     <= txn_err_d;
            cs_n_q        <= cs_n_d;
            spi_start_q   <= spi_start_d;
            spi_wdata_q   <= spi_wdata_d;
`ifdef SPI_ARB_TIMEOUT_EN
            tmo_q         <= tmo_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign wdata_ack   = wdata_ack_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign txn_done    = txn_done_q;
    assign txn_err     = txn_err_q;
    assign cs_n        = cs_n_q;
    assign spi_start   = spi_start_q;
    assign spi_wdata   = spi_wdata_q;

endmodule
